disp_scan_ctrl: RTL and testbench

- Time-multiplexed driver for the calculator's 4-digit common-anode 7-segment display.
- Holds a frame of four hex nibbles plus a per-digit blank mask. The mask comes from the calculator's blanking/command logic.
- Scans the digits round-robin with an anode-off guard gap between slots.
- Commits new frames only at frame boundaries, so the display never tears mid-frame.

---
 rtl/disp_pkg.sv | 39 +++
 rtl/disp_scan_ctrl_hex7seg.sv | 13 +
 rtl/disp_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the 4-digit 7-segment scan controller.
//   NUM_DIGITS      - number of multiplexed digits
//   SEG_OFF, AN_OFF - all-dark levels for the active-low segment/anode pins
//   scan_state_t    - per-slot scan state (GAP = anodes off, ON = digit lit)
//   HEX_SEG         - hex nibble to active-low {g,f,e,d,c,b,a} glyph table
//   lead_zero_mask  - digits above the most significant nonzero digit
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic {
    GAP = 1'b0,
    ON  = 1'b1
  } scan_state_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}; A..F use the A,b,C,d,E,F shapes.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Bit i set when digit i is a leading zero. Digit 0 is never flagged so
  // that a zero value still shows a single "0".
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] d);
    logic [3:0] m;
    m    = 4'h0;
    m[3] = (d[15:12] == 4'h0);
    m[2] = m[3] && (d[11:8] == 4'h0);
    m[1] = m[2] && (d[7:4] == 4'h0);
    return m;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_hex7seg.sv
// hex7seg: combinational hex nibble to active-low 7-segment decoder.
//   nibble - 4-bit hex value
//   seg_n  - segments {g,f,e,d,c,b,a}, active low
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed driver for a 4-digit common-anode
// 7-segment display with an anode-off guard gap at the start of each slot
// and tear-free frame commits.
//
// Parameters:
//   SCAN_DIV   - clock cycles per digit slot (2..65535)
//   GAP_CYCLES - all-anodes-off cycles at slot start (0 = no gap, < SCAN_DIV)
//
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   load        - single-cycle strobe capturing data/blank into staging
//   data[15:0]  - four hex digits, [3:0] = digit 0 (rightmost)
//   blank[3:0]  - per-digit blank request (1 = dark)
//   seg_n[6:0]  - segments {g,f,e,d,c,b,a}, active low (registered)
//   an_n[3:0]   - digit anodes, active low (registered)
//   frame_start - one-cycle pulse in the first cycle of digit 0's slot
//   pending     - a staged frame is waiting for the next frame boundary
//
// Build option:
//   LEAD_ZERO_BLANK_EN - when defined, leading zero digits (never digit 0)
//                        are auto-blanked at commit, ORed with the blank mask.
//
// Handshake: load is a plain strobe with no back-pressure; every load is
// accepted in the cycle it is high. The last load before a commit wins.
//
// Timing: pins are registered from the current prescaler/index/state, so
// the pins trail the internal scan position by exactly one cycle. The scan
// state is held in 'state' (type scan_state_t) for probing.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV   = 16'd50000,
  parameter logic [15:0] GAP_CYCLES = 16'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  blank,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_start,
  output logic        pending
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [15:0]      presc;
  logic [15:0]      presc_nxt;
  logic [IDX_W-1:0] idx;
  scan_state_t      state;

  logic [15:0] stg_data;
  logic [3:0]  stg_blank;
  logic [15:0] act_data;
  logic [3:0]  act_blank;

  logic        slot_end;
  logic        commit;
  logic [15:0] src_data;
  logic [3:0]  src_blank;
  logic [3:0]  src_blank_eff;
  logic [3:0]  cur_nib;
  logic [6:0]  cur_seg;
  logic        lit;

  always_comb begin
    slot_end  = (presc == SCAN_DIV - 16'd1);
    presc_nxt = slot_end ? 16'd0 : presc + 16'd1;
    commit    = slot_end && (idx == LAST_IDX);

    // A load coinciding with the commit bypasses staging.
    src_data  = load ? data  : stg_data;
    src_blank = load ? blank : stg_blank;
`ifdef LEAD_ZERO_BLANK_EN
    src_blank_eff = src_blank | lead_zero_mask(src_data);
`else
    src_blank_eff = src_blank;
`endif

    cur_nib = act_data[{idx, 2'b00} +: 4];
    // With no gap configured the reset state (GAP) is already a lit slot.
    lit = ((state == ON) || (GAP_CYCLES == 16'd0)) && !act_blank[idx];
  end

  hex7seg u_hex7seg (
    .nibble (cur_nib),
    .seg_n  (cur_seg)
  );

  // Scan FSM: prescaler, digit index, slot state and registered pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= 16'd0;
      idx         <= '0;
      state       <= GAP;
      seg_n       <= SEG_OFF;
      an_n        <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      presc <= presc_nxt;
      if (slot_end) idx <= idx + 1'b1;

      case (state)
        // Leave the gap so that ON coincides with prescaler == GAP_CYCLES.
        GAP:     if (presc_nxt >= GAP_CYCLES) state <= ON;
        ON:      if (slot_end && (GAP_CYCLES != 16'd0)) state <= GAP;
        default: state <= GAP;
      endcase

      frame_start <= (presc == 16'd0) && (idx == '0);
      an_n        <= lit ? ~(4'b0001 << idx) : AN_OFF;
      seg_n       <= lit ? cur_seg : SEG_OFF;
    end
  end

  // Staging and frame commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data  <= 16'h0000;
      stg_blank <= 4'hF;
      act_data  <= 16'h0000;
      act_blank <= 4'hF;
      pending   <= 1'b0;
    end else begin
      if (load) begin
        stg_data  <= data;
        stg_blank <= blank;
      end
      if (commit) begin
        if (load || pending) begin
          act_data  <= src_data;
          act_blank <= src_blank_eff;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for disp_scan_ctrl (SCAN_DIV=8,
// GAP_CYCLES=2, one frame = 32 cycles). The driver pushes the expected
// {data, blank} of each upcoming frame into exp_q; the monitor pops one entry
// at every frame_start and checks every pin cycle of that frame.
module tb_disp_scan_ctrl;

  localparam int SDIV  = 8;
  localparam int GAPC  = 2;
  localparam int FRAME = 4 * SDIV;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic [3:0]  blank;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;
  logic        pending;

  disp_scan_ctrl #(
    .SCAN_DIV   (16'd8),
    .GAP_CYCLES (16'd2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data        (data),
    .blank       (blank),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start),
    .pending     (pending)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          p;             // index of the last rising edge since reset release
  logic [15:0] lat_d;         // most recent load, as the model sees it
  logic [3:0]  lat_b;
  logic        exp_pending;
  logic        mon_en;
  int          mphase;
  logic [19:0] cur_frame;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lz_model(input logic [15:0] d);
    logic [3:0] m;
    m = 4'h0;
`ifdef LEAD_ZERO_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < 4; i++) if (d[4*i +: 4] != 4'h0) msd = i;
      for (int i = 0; i < 4; i++) if (i > msd) m[i] = 1'b1;
    end
`endif
    return m;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      int          k;
      int          c;
      logic [3:0]  eb;
      logic [3:0]  nib;
      logic        lit;
      logic [3:0]  e_an;
      logic [6:0]  e_seg;
      chk("frame_start", 16'(frame_start), 16'(mphase == 0));
      if (frame_start) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL exp_q_empty: got frame_start with no expected frame at t=%0t", $time);
        end else begin
          cur_frame = exp_q.pop_front();
        end
      end
      k     = mphase / SDIV;
      c     = mphase % SDIV;
      eb    = cur_frame[3:0] | lz_model(cur_frame[19:4]);
      nib   = cur_frame[4 + 4*k +: 4];
      lit   = (c >= GAPC) && !eb[k];
      e_an  = lit ? ~(4'b0001 << k) : 4'hF;
      e_seg = lit ? glyph[nib] : 7'h7F;
      chk("an_n", 16'(an_n), 16'(e_an));
      chk("seg_n", 16'(seg_n), 16'(e_seg));
      chk("pending", 16'(pending), 16'(exp_pending));
      mphase = (mphase + 1) % FRAME;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n  = 1'b0;
    load   = 1'b0;
    data   = 16'h0;
    blank  = 4'h0;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_seg_n", 16'(seg_n), 16'h7F);
    chk("rst_an_n", 16'(an_n), 16'hF);
    chk("rst_frame_start", 16'(frame_start), 16'h0);
    chk("rst_pending", 16'(pending), 16'h0);
    exp_q.delete();
    lat_d = 16'h0000;
    lat_b = 4'hF;
    exp_q.push_back({lat_d, lat_b});
    exp_pending = 1'b0;
    mphase      = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    p      = 0;
    mon_en = 1'b1;
  endtask

  // Drive one cycle; inputs are sampled at the next rising edge (edge p+1).
  task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] b);
    @(negedge clk);
    load  = ld;
    data  = d;
    blank = b;
    @(posedge clk);
    p++;
    if (ld) begin
      lat_d = d;
      lat_b = b;
    end
    // Edge at the end of digit 3's slot commits whatever was last loaded.
    if ((p % FRAME) == FRAME - 1) begin
      exp_q.push_back({lat_d, lat_b});
      exp_pending = 1'b0;
    end else if (ld) begin
      exp_pending = 1'b1;
    end
  endtask

  task automatic load_at(input int e, input logic [15:0] d, input logic [3:0] b);
    while (p < e - 1) tick(1'b0, 16'h0, 4'h0);
    tick(1'b1, d, b);
  endtask

  task automatic rand_tick();
    logic        ld;
    logic [15:0] d;
    logic [3:0]  b;
    int          sh;
    ld = ($urandom_range(0, 11) == 0) ||
         ((((p + 1) % FRAME) == FRAME - 1) && ($urandom_range(0, 2) == 0));
    sh = $urandom_range(0, 4);
    d  = 16'($urandom);
    d  = d >> (4 * sh);
    b  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
    tick(ld, d, b);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int kk;
    cur_frame = {16'h0000, 4'hF};
    do_reset();

    // Directed patterns, then random traffic.
    load_at(5,   16'h1234, 4'h0);
    load_at(40,  16'hAAAA, 4'h0);
    load_at(50,  16'hBEEF, 4'h0);
    load_at(70,  16'h8888, 4'b0101);
    load_at(127, 16'h0042, 4'h0);   // coincident with a commit
    load_at(140, 16'h0007, 4'h0);
    load_at(180, 16'h0000, 4'h0);
    load_at(215, 16'h5A0C, 4'h0);
    while (p < 1100) rand_tick();

    // Reset in the middle of a lit slot, with a second frame still staged.
    load_at(p + 1, 16'h1234, 4'h0);
    kk = p / FRAME + 1;
    load_at(FRAME * kk + 1, 16'h5678, 4'h0);
    while (p < FRAME * kk + 2) tick(1'b0, 16'h0, 4'h0);
    #2;
    chk("pre_rst_an_n", 16'(an_n), 16'hE);
    chk("pre_rst_seg_n", 16'(seg_n), 16'h19);
    chk("pre_rst_pending", 16'(pending), 16'h1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_rst_seg_n", 16'(seg_n), 16'h7F);
    chk("async_rst_an_n", 16'(an_n), 16'hF);
    chk("async_rst_pending", 16'(pending), 16'h0);

    // Staged data is gone: display stays dark until a new load.
    do_reset();
    while (p < 3 * FRAME) tick(1'b0, 16'h0, 4'h0);
    while (p < 500) rand_tick();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
